ysyx_23060203_div: RTL and testbench

YSYX_23060203_DIV -- requirements
Module: ysyx_23060203_DIV

---
 rtl/ysyx_23060203_div_pkg.sv | 30 +++
 rtl/ysyx_23060203_div.sv | 137 +++++++++++++
 tb/tb_ysyx_23060203_div.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_div_pkg.sv
// Shared encodings for the iterative 32-bit divider: operation codes, FSM states
// and the datapath width.
package ysyx_23060203_div_pkg;

    localparam int unsigned Width = 32;
    localparam int unsigned CntW  = 6;
    localparam logic [CntW-1:0] LastIter = 6'd31;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/ysyx_23060203_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// single-cycle fast path for divide-by-zero and signed overflow, registered outputs.
module ysyx_23060203_div
    import ysyx_23060203_div_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Width-1:0]  in_a,
    input  logic [Width-1:0]  in_b,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Width-1:0]  out_val
);

    div_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] quo_q, rem_q, dvs_q;
    logic             neg_quo_q, neg_rem_q, is_rem_q;
    logic             in_ready_q, out_valid_q;
    logic [Width-1:0] out_val_q;

    // Request decode
    div_op_e          op_in;
    logic             sgn_in, rem_in, a_neg, b_neg, div_zero, ovf, fast;
    logic [Width-1:0] a_mag, b_mag, fast_val;

    always_comb begin
        op_in    = div_op_e'(in_op);
        sgn_in   = op_is_signed(op_in);
        rem_in   = op_is_rem(op_in);
        a_neg    = sgn_in & in_a[Width-1];
        b_neg    = sgn_in & in_b[Width-1];
        a_mag    = a_neg ? (~in_a + 32'd1) : in_a;
        b_mag    = b_neg ? (~in_b + 32'd1) : in_b;
        div_zero = (in_b == 32'd0);
        ovf      = sgn_in && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
        fast     = div_zero | ovf;
        if (div_zero) begin
            fast_val = rem_in ? in_a : 32'hFFFF_FFFF;
        end else begin
            fast_val = rem_in ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step; bit 32 of the difference is the borrow.
    logic [Width:0]   rem_shift, diff;
    logic             ge;
    logic [Width-1:0] quo_nxt, rem_nxt, quo_fix, rem_fix, fin_val;

    always_comb begin
        rem_shift = {rem_q, quo_q[Width-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        ge        = ~diff[Width];
        rem_nxt   = ge ? diff[Width-1:0] : rem_shift[Width-1:0];
        quo_nxt   = {quo_q[Width-2:0], ge};
        quo_fix   = neg_quo_q ? (~quo_nxt + 32'd1) : quo_nxt;
        rem_fix   = neg_rem_q ? (~rem_nxt + 32'd1) : rem_nxt;
        fin_val   = is_rem_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            is_rem_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
        end else if (flush) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        is_rem_q   <= rem_in;
                        if (fast) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            out_val_q   <= fast_val;
                        end else begin
                            state_q <= StCalc;
                            cnt_q   <= '0;
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            dvs_q   <= b_mag;
                        end
                    end
                end
                StCalc: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    if (cnt_q == LastIter) begin
                        cnt_q       <= '0;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        out_val_q   <= fin_val;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;

endmodule

// File: tb/tb_ysyx_23060203_div.sv
// Scoreboard bench for ysyx_23060203_div: the driver queues expected results at
// accept time, a monitor checks value, latency, stability and handshake rules.
module tb_ysyx_23060203_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_val;

    ysyx_23060203_div dut (
        .clock     (clk),
        .reset     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a request starting just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit track);
        int n = 0;
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 (cycle %0d)", cyc);
        end else if (track) begin
            sb.push_back('{val: exp, lat: lat, t_acc: cyc});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        exp_t cur;
        bit   holding = 1'b0;
        bit   prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
                    prev_hs = 1'b0;
                end
                if (out_valid) begin
                    chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                    if (!holding) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_out: got 0x%08h expected no result", out_val);
                            cur = '{val: out_val, lat: 0, t_acc: cyc};
                        end else begin
                            cur = sb.pop_front();
                            chk("result", out_val, cur.val);
                            chk("latency", 32'(cyc - cur.t_acc), 32'(cur.lat));
                        end
                        holding = 1'b1;
                    end else begin
                        chk("stable_val", out_val, cur.val);
                    end
                    if (out_ready) begin
                        holding = 1'b0;
                        prev_hs = 1'b1;
                    end
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_val", out_val, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        issue(2'b01, 32'd100, 32'd7, 32'd14, 33, 1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1);
        issue(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
        issue(2'b11, 32'd5, 32'd0, 32'd5, 1, 1);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 33, 1);
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1);
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1);
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 1);

        // Consumer stall: hold out_ready low for 10 cycles of out_valid.
        issue(2'b01, 32'd9, 32'd3, 32'd3, 33, 1);
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        step(2);

        // Flush in CALC cycle 15 of a request that must never produce a result.
        issue(2'b01, 32'd1000, 32'd3, 32'd0, 0, 0);
        step(14);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        step(1);
        issue(2'b01, 32'd8, 32'd2, 32'd4, 33, 1);

        // Reset mid-CALC discards the operation.
        issue(2'b01, 32'd50, 32'd5, 32'd0, 0, 0);
        step(5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_val", out_val, 32'd0);
        step(1);
        issue(2'b00, 32'd20, 32'd6, 32'd3, 33, 1);

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        step(50);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
